// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared encodings for the iterative multiply/divide unit
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    localparam int ITERATIONS = 32;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - 32-iteration shift-add multiplier / restoring divider with HI/LO result registers
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  MDOperation,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

    md_state_t   state, state_nxt;
    md_op_t      op_q;
    logic [5:0]  cnt;
    logic        neg_res, neg_rem, b_zero;
    logic [31:0] work_hi, work_lo, work_b;

    md_op_t      op_in;
    logic        in_signed, in_div, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;

    logic        is_div, last_iter;
    logic [32:0] mul_sum, div_shift;
    logic        div_ge;
    logic [31:0] div_diff, step_hi, step_lo;
    logic [63:0] prod_raw, prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // operand conditioning at capture: signed ops work on magnitudes
    always_comb begin
        op_in     = md_op_t'(MDOperation);
        in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
        in_div    = (op_in == MD_DIVU) || (op_in == MD_DIV);
        a_neg     = in_signed & A[31];
        b_neg     = in_signed & B[31];
        mag_a     = a_neg ? (32'd0 - A) : A;
        mag_b     = b_neg ? (32'd0 - B) : B;
    end

    // one iteration: multiply shifts right through {hi,lo}, divide shifts left
    always_comb begin
        is_div    = (op_q == MD_DIVU) || (op_q == MD_DIV);
        last_iter = (cnt == LAST_ITER);
        mul_sum   = {1'b0, work_hi} + {1'b0, (work_lo[0] ? work_b : 32'd0)};
        div_shift = {work_hi, work_lo[31]};
        div_ge    = div_shift >= {1'b0, work_b};
        div_diff  = div_shift[31:0] - work_b;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_shift[31:0];
            step_lo = {work_lo[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], work_lo[31:1]};
        end
        prod_raw = {step_hi, step_lo};
        prod_fix = neg_res ? (64'd0 - prod_raw) : prod_raw;
        quo_fix  = b_zero ? 32'hFFFF_FFFF : (neg_res ? (32'd0 - step_lo) : step_lo);
        rem_fix  = neg_rem ? (32'd0 - step_hi) : step_hi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        DivByZero = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) state_nxt = ST_CALC;
            end
            ST_CALC: begin
                Busy = 1'b1;
                if (last_iter) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                Done      = 1'b1;
                DivByZero = b_zero;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= MD_MULTU;
            cnt     <= 6'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            work_hi <= 32'd0;
            work_lo <= 32'd0;
            work_b  <= 32'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        op_q    <= op_in;
                        cnt     <= 6'd0;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        b_zero  <= in_div && (B == 32'd0);
                        work_hi <= 32'd0;
                        work_lo <= in_div ? mag_a : mag_b;
                        work_b  <= in_div ? mag_b : mag_a;
                    end
                end
                ST_CALC: begin
                    cnt     <= cnt + 6'd1;
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    if (last_iter) begin
                        HI <= is_div ? rem_fix : prod_fix[63:32];
                        LO <= is_div ? quo_fix : prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vector bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  MDOperation = 2'b00;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy, Done, DivByZero;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOperation(MDOperation),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start is sampled on the edge after this negedge (edge 0); cycle k is seen at the k-th following negedge
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int repulse_cyc,
                          output int done_cyc, output int busy_cnt, output int done_cnt,
                          output logic dz_at_done);
        done_cyc = -1; busy_cnt = 0; done_cnt = 0; dz_at_done = 1'b0;
        @(negedge clk);
        MDOperation = op; A = a; B = b; Start = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            Start = (cyc == repulse_cyc);
            A = $urandom; B = $urandom; MDOperation = 2'($urandom_range(0, 3));
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    dz_at_done = DivByZero;
                end
            end
        end
        Start = 1'b0;
    endtask

    initial begin
        int dc, bc, nc;
        logic dz;
        logic [31:0] hold_hi, hold_lo;
        int stray;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b10, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{2'b00, 32'd6,        32'd7,        32'h00000000, 32'd42,       1'b0};
        vecs[6]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[7]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{2'b11, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0};

        #12;
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_dz", 64'(DivByZero), 64'd0);
        chk("reset_hi", 64'(HI), 64'd0);
        chk("reset_lo", 64'(LO), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, dc, bc, nc, dz);
            chk($sformatf("v%0d_latency", i), 64'(dc), 64'd33);
            chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd32);
            chk($sformatf("v%0d_done_pulses", i), 64'(nc), 64'd1);
            chk($sformatf("v%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
            chk($sformatf("v%0d_hi", i), 64'(HI), 64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(LO), 64'(vecs[i].lo));
        end

        // second Start while busy must be dropped
        run_op(2'b00, 32'd6, 32'd7, 10, dc, bc, nc, dz);
        chk("repulse_latency", 64'(dc), 64'd33);
        chk("repulse_done_pulses", 64'(nc), 64'd1);
        chk("repulse_hi", 64'(HI), 64'd0);
        chk("repulse_lo", 64'(LO), 64'd42);

        // results hold while idle
        hold_hi = HI; hold_lo = LO;
        repeat (5) @(negedge clk);
        chk("hold_hi", 64'(HI), 64'(hold_hi));
        chk("hold_lo", 64'(LO), 64'd42);

        // reset in the middle of a divide
        @(negedge clk);
        MDOperation = 2'b10; A = 32'd1000; B = 32'd3; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid_busy_before_reset", 64'(Busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_reset_busy", 64'(Busy), 64'd0);
        chk("mid_reset_hi", 64'(HI), 64'd0);
        chk("mid_reset_lo", 64'(LO), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (Done || Busy) stray++;
        end
        chk("post_reset_no_done", 64'(stray), 64'd0);

        run_op(2'b10, 32'd1000, 32'd3, 0, dc, bc, nc, dz);
        chk("post_reset_latency", 64'(dc), 64'd33);
        chk("post_reset_hi", 64'(HI), 64'd1);
        chk("post_reset_lo", 64'(LO), 64'd333);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
